// File: rtl/charger_detect_qualifier_pkg.sv
// Shared definitions for the charger detect qualifier and its consumers.
// Holds the detect FSM state encoding, the default timing constants and a
// helper that tells which states run the shared timer.
package bms_pkg;

  // Default timing; the fast-charging controller and the bench use these too.
  localparam int unsigned CHG_DEBOUNCE_CYCLES   = 16;
  localparam int unsigned CHG_HS_TIMEOUT_CYCLES = 64;
  localparam int unsigned CHG_LOCKOUT_CYCLES    = 256;
  localparam int unsigned CHG_MAX_RETRIES       = 3;
  localparam int unsigned CHG_CNT_W             = 9;

  typedef enum logic [2:0] {
    UNPLUGGED     = 3'd0,
    DEBOUNCE      = 3'd1,
    HANDSHAKE     = 3'd2,
    PLUGGED       = 3'd3,
    LOCKOUT       = 3'd4,
    FAULT_LATCHED = 3'd5
  } chg_det_state_t;

  // States in which the shared timer counts.
  function automatic logic chg_is_timed(chg_det_state_t s);
    return (s == DEBOUNCE) || (s == HANDSHAKE) || (s == LOCKOUT);
  endfunction

endpackage

// File: rtl/charger_detect_qualifier_if.sv
// Signal bundle between the charger-side pins and the detect qualifier.
// master: drives the plug pin, VBUS/temperature flags and charger ack.
// slave : the qualifier; drives hs_req, charger_plugged, fault, retry_cnt, det_state.
interface charger_detect_qualifier_if;
  logic       plug_raw;
  logic       vbus_ok;
  logic       temp_fault;
  logic       hs_ack;
  logic       hs_req;
  logic       charger_plugged;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] det_state;

  modport master (
    output plug_raw, vbus_ok, temp_fault, hs_ack,
    input  hs_req, charger_plugged, fault, retry_cnt, det_state
  );

  modport slave (
    input  plug_raw, vbus_ok, temp_fault, hs_ack,
    output hs_req, charger_plugged, fault, retry_cnt, det_state
  );
endinterface

// File: rtl/charger_detect_qualifier_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
// Ports: clk, reset (async, active-high), d (async input), q (synced, 2 clk latency).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/charger_detect_qualifier.sv
// Charger detect qualifier: synchronises/debounces plug detect, handshakes with
// the charger, qualifies on VBUS and temperature, and locks out with bounded retries.
// Ports: clk, reset (async, active-high), bus (slave modport: pins in, status out).
// All outputs are registered Moore decodes of the state; no input-to-output path.
// Every *_CYCLES parameter must be <= 2**CNT_W; MAX_RETRIES must be 1..3.
module charger_detect_qualifier
  import bms_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = CHG_DEBOUNCE_CYCLES,
  parameter int unsigned HS_TIMEOUT_CYCLES = CHG_HS_TIMEOUT_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES    = CHG_LOCKOUT_CYCLES,
  parameter int unsigned MAX_RETRIES       = CHG_MAX_RETRIES,
  parameter int unsigned CNT_W             = CHG_CNT_W
) (
  input logic                       clk,
  input logic                       reset,
  charger_detect_qualifier_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HS_LAST     = CNT_W'(HS_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LAST     = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  logic plug_sync;

  sync_2ff u_plug_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.plug_raw),
    .q     (plug_sync)
  );

  chg_det_state_t   state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d;
  logic             hs_req_q, hs_req_d;
  logic             plugged_q, plugged_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    if (!plug_sync) begin
      // Removal overrides everything and forgets past lockouts.
      state_d = UNPLUGGED;
      retry_d = 2'd0;
    end else if (bus.temp_fault && (state_q == HANDSHAKE || state_q == PLUGGED)) begin
      // Checked ahead of the ack so a hot charger is never accepted.
      state_d = LOCKOUT;
    end else begin
      case (state_q)
        UNPLUGGED: state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (timer_q == DB_LAST) state_d = HANDSHAKE;
        end
        HANDSHAKE: begin
          // Ack is tested before the timeout so it wins a same-cycle tie.
          if (bus.hs_ack && bus.vbus_ok) begin
            state_d = PLUGGED;
            retry_d = 2'd0;
          end else if (timer_q == HS_LAST) begin
            state_d = LOCKOUT;
          end
        end
        PLUGGED: begin
          if (!bus.vbus_ok || !bus.hs_ack) state_d = LOCKOUT;
        end
        LOCKOUT: begin
          if (timer_q == LO_LAST)
            state_d = (retry_q >= RETRY_LIMIT) ? FAULT_LATCHED : DEBOUNCE;
        end
        FAULT_LATCHED: state_d = FAULT_LATCHED;
        default:       state_d = UNPLUGGED;
      endcase
    end

    // Count each lockout once, on entry, saturating at 3.
    if (state_d == LOCKOUT && state_q != LOCKOUT && retry_q != 2'd3)
      retry_d = retry_q + 2'd1;

    timer_d = '0;
    if (state_d == state_q && chg_is_timed(state_q))
      timer_d = timer_q + 1'b1;

    // Decoding from the next state makes the registered outputs track the state register.
    hs_req_d  = (state_d == HANDSHAKE) || (state_d == PLUGGED);
    plugged_d = (state_d == PLUGGED);
    fault_d   = (state_d == LOCKOUT) || (state_d == FAULT_LATCHED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= UNPLUGGED;
      timer_q   <= '0;
      retry_q   <= 2'd0;
      hs_req_q  <= 1'b0;
      plugged_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      hs_req_q  <= hs_req_d;
      plugged_q <= plugged_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.hs_req          = hs_req_q;
  assign bus.charger_plugged = plugged_q;
  assign bus.fault           = fault_q;
  assign bus.retry_cnt       = retry_q;
  assign bus.det_state       = state_q;

endmodule
